red_pitaya_iq_decimate_block: RTL
=================================

RED_PITAYA_IQ_DECIMATE_BLOCK -- requirements
Module: red_pitaya_iq_decimate_block

Interface
REQ-001 SHALL have parameter LPFBITS, default 18: width of input and output samples, matching the upstream IQ low-pass filter output.
REQ-002 SHALL have parameter MAXLOG2, default 14: largest supported log2 of the decimation factor.
REQ-003 SHALL have clk_i, input, 1 bit: the single clock; all logic is rising-edge triggered on it.
REQ-004 SHALL have reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have enable_i, input, 1 bit: run request; 0 forces idle.
REQ-006 SHALL have log2_n_i, input, 4 bits, unsigned: log2 of the decimation factor N.
REQ-007 SHALL have signal_i, input, LPFBITS bits, signed: low-pass filtered sample, one per clock.
REQ-008 SHALL have signal_o, output, LPFBITS bits, signed: average of the last completed window.
REQ-009 SHALL have valid_o, output, 1 bit: one-cycle strobe marking a new signal_o.
REQ-010 SHALL have busy_o, output, 1 bit: high while a window is accumulating.

Function
REQ-011 SHALL implement a two-state FSM, IDLE and ACCUM, with busy_o = (state == ACCUM), registered.
REQ-012 SHALL, in IDLE with enable_i=1, clear the accumulator and counter, latch n_shift = min(log2_n_i, MAXLOG2), and enter ACCUM on the next cycle; the signal_i present during the IDLE cycle is not accumulated.
REQ-013 SHALL, in ACCUM with enable_i=1, add sign-extended signal_i to an accumulator of LPFBITS+MAXLOG2 bits each cycle and increment the sample counter; accumulator overflow is impossible by construction.
REQ-014 SHALL, on the cycle the N-th sample (N = 2^n_shift) is present, register signal_o = (accumulator + signal_i) >>> n_shift, arithmetic shift (floor rounding, no saturation needed), truncated to LPFBITS bits, and register valid_o = 1.
REQ-015 SHALL, on that same cycle, zero the accumulator and counter and re-latch n_shift from log2_n_i, so the next window starts on the following sample with no gap.
REQ-016 SHALL hold valid_o high for exactly one cycle per completed window; signal_o holds its value between strobes.
REQ-017 SHALL, for N=1, assert valid_o on every ACCUM cycle with signal_o equal to signal_i delayed by one cycle.
REQ-018 SHALL ignore changes to log2_n_i during a window; they take effect at the next window boundary only.
REQ-019 SHALL, when enable_i=0 in ACCUM, return to IDLE on the next cycle, discard the partial window, and keep valid_o=0; signal_o retains its last value.

Reset
REQ-020 SHALL, while reset_i=1, set state=IDLE, accumulator=0, counter=0, n_shift=0, signal_o=0, valid_o=0, busy_o=0; reset overrides enable_i and discards any partial window.
REQ-021 SHALL, after reset_i falls with enable_i=1, behave exactly as a fresh IDLE-to-ACCUM start per REQ-012.

Verification
REQ-022 SHALL be verified with log2_n_i=2, signal_i=1000 constant, enable_i rising at cycle 0 -> busy_o=1 from cycle 1, first valid_o at cycle 5, then every 4 cycles, signal_o=1000.
REQ-023 SHALL be verified with log2_n_i=14 and constant signal_i=-131072, then 131071 -> signal_o=-131072, then 131071, with no wrap.
REQ-024 SHALL be verified with log2_n_i=1 and samples (-1,0) -> signal_o=-1; samples (3,0) -> signal_o=1 (floor).
REQ-025 SHALL be verified with log2_n_i=0 and a ramp input -> valid_o continuously high and signal_o equal to the ramp delayed by one cycle.
REQ-026 SHALL be verified with log2_n_i=3, reset_i pulsed after 5 samples -> no valid_o and all outputs 0; with enable held, the first valid_o comes 9 cycles after reset release and averages only post-reset samples.
REQ-027 SHALL be verified with log2_n_i switched from 2 to 3 mid-window -> the current window closes after 4 samples and the next after 8; log2_n_i=15 -> windows of 16384 samples.

Source files
------------

// File: rtl/red_pitaya_iq_decimate_block.sv
// Boxcar decimator for one IQ channel.
// It averages blocks of N = 2^n_shift consecutive low-pass filtered samples.
// It emits one averaged sample per window, with a one-cycle valid strobe.
//
// Handshake: there is no backpressure. signal_i is consumed on every
// ACCUM cycle while enable_i is high. When valid_o is high for one cycle,
// the value on signal_o is new. Between strobes, signal_o holds its value.
module red_pitaya_iq_decimate_block #(
   parameter int LPFBITS = 18,
   parameter int MAXLOG2 = 14
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      enable_i,
   input  logic [3:0]                log2_n_i,
   input  logic signed [LPFBITS-1:0] signal_i,
   output logic signed [LPFBITS-1:0] signal_o,
   output logic                      valid_o,
   output logic                      busy_o
);

   // The accumulator holds a full 2^MAXLOG2-sample sum, so it cannot wrap.
   localparam int AW = LPFBITS + MAXLOG2;
   localparam int CW = MAXLOG2 + 1;
   localparam logic [3:0] MAX_SH = 4'(MAXLOG2);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t                  state;
   logic signed [AW-1:0]    acc;
   logic signed [AW-1:0]    sum;
   logic signed [AW-1:0]    avg_full;
   logic [CW-1:0]           cnt;
   logic [CW-1:0]           last_cnt;
   logic [3:0]              n_shift;
   logic [3:0]              n_next;
   logic                    window_done;

   // Compute the next-window shift (clamped), the running sum including the
   // current sample, and the floor-rounded window average.
   always_comb begin
      n_next      = (log2_n_i > MAX_SH) ? MAX_SH : log2_n_i;
      sum         = acc + $signed({{MAXLOG2{signal_i[LPFBITS-1]}}, signal_i});
      avg_full    = sum >>> n_shift;
      last_cnt    = (CW'(1) << n_shift) - CW'(1);
      window_done = (cnt == last_cnt);
   end

   // Control FSM and datapath registers. busy_o mirrors the state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state    <= IDLE;
         busy_o   <= 1'b0;
         acc      <= '0;
         cnt      <= '0;
         n_shift  <= '0;
         signal_o <= '0;
         valid_o  <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (enable_i) begin
                  acc     <= '0;
                  cnt     <= '0;
                  n_shift <= n_next;
                  state   <= ACCUM;
                  busy_o  <= 1'b1;
               end
            end
            ACCUM: begin
               if (!enable_i) begin
                  // Drop the partial window; signal_o keeps the last average.
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else if (window_done) begin
                  // Close this window. The next window starts with the next
                  // sample and uses a freshly latched length.
                  signal_o <= LPFBITS'(avg_full);
                  valid_o  <= 1'b1;
                  acc      <= '0;
                  cnt      <= '0;
                  n_shift  <= n_next;
               end else begin
                  acc <= sum;
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
